alu_arbiter: RTL and testbench

Shares the single 16-bit combinational ALU between two requesters: the pipeline execute stage (port 0) and the address/branch-compare unit (port 1). Each requester issues operand pairs and an opcode over a valid/ready handshake. The arbiter picks one request per cycle by round-robin and drives the ALU inputs. It captures the result and zero flag in a one-entry response register tagged with the winner's ID.

---
 rtl/alu_arb_pkg.sv | 25 ++
 rtl/alu_arbiter_rr_arb2.sv | 43 ++++
 rtl/alu_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the two-port ALU arbiter.
// Holds the ALU opcode encodings, the requester ID type and the response-slot
// state enum used by alu_arbiter and rr_arb2.
package alu_arb_pkg;

    // ALU opcodes, forwarded to the ALU unmodified.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_SHL = 3'b011;
    localparam logic [2:0] ALU_SHR = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Requester identifier: 0 = execute stage, 1 = address/branch unit.
    typedef logic req_id_t;

    // One-entry response register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: purely combinational 2-way round-robin picker.
// Ports:
//   valid_i    [1:0] request valid per requester
//   last_i           requester that won the previous grant
//   hold_i           give priority to last_i instead of rotating (lock)
//   grant_o    [1:0] one-hot grant, 2'b00 when nothing is valid
//   grant_id_o       index of the winner, 0 when nothing is valid
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  req_id_t    last_i,
    input  logic       hold_i,
    output logic [1:0] grant_o,
    output req_id_t    grant_id_o
);

    // Winner selection: a lone request wins outright; under contention the
    // requester that did not win last time is picked unless hold_i is set.
    always_comb begin
        grant_id_o = 1'b0;
        grant_o    = 2'b00;
        case (valid_i)
            2'b01: begin
                grant_id_o = 1'b0;
                grant_o    = 2'b01;
            end
            2'b10: begin
                grant_id_o = 1'b1;
                grant_o    = 2'b10;
            end
            2'b11: begin
                grant_id_o = hold_i ? last_i : ~last_i;
                grant_o    = grant_id_o ? 2'b10 : 2'b01;
            end
            default: begin
                grant_id_o = 1'b0;
                grant_o    = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 16-bit ALU between the execute stage
// (requester 0) and the address/branch-compare unit (requester 1). One request
// per cycle is granted round-robin; the ALU result is captured in a one-entry
// response register tagged with the winner's ID.
// Optional feature macro: ALU_ARB_LOCK_EN adds the req_lock port and a
// saturating lock counter allowing up to LOCK_MAX back-to-back grants.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester handshake
//   req_a0/b0/op0, req_a1/b1/op1  operands and opcode per requester
//   req_lock [1:0]             lock request (ALU_ARB_LOCK_EN only)
//   alu_in1/alu_in2/alu_ctrl   drive the shared ALU
//   alu_out/alu_zero           ALU result and zero flag
//   rsp_valid/rsp_id/rsp_data/rsp_zero/rsp_ready  registered response
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [2:0]  req_op0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    input  logic [2:0]  req_op1,
`ifdef ALU_ARB_LOCK_EN
    input  logic [1:0]  req_lock,
`endif
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [2:0]  alu_ctrl,
    input  logic [15:0] alu_out,
    input  logic        alu_zero,
    output logic        rsp_valid,
    output req_id_t     rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_zero,
    input  logic        rsp_ready
);

    if (LOCK_MAX < 1) begin : g_bad_lock_max
        $error("alu_arbiter: LOCK_MAX must be at least 1");
    end

    rsp_state_e  state_q, state_d;
    req_id_t     last_grant_q;
    req_id_t     rsp_id_q;
    logic [15:0] rsp_data_q;
    logic        rsp_zero_q;

    logic        slot_free_s;
    logic        hold_s;
    logic [1:0]  grant_s;
    req_id_t     grant_id_s;
    logic        transfer_s;

    // The slot can take a new result when empty or when it drains this cycle.
    assign slot_free_s = (state_q == EMPTY) | rsp_ready;

`ifdef ALU_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    // The last winner keeps priority only while locked and below its budget.
    assign hold_s = req_lock[last_grant_q] & (lock_cnt_q < CNT_W'(LOCK_MAX));

    // Lock counter: counts consecutive locked grants to the same owner,
    // restarts on owner change and clears when the owner's lock drops.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (transfer_s) begin
            if (!req_lock[grant_id_s]) begin
                lock_cnt_d = CNT_W'(0);
            end else if (grant_id_s != last_grant_q) begin
                lock_cnt_d = CNT_W'(1);
            end else if (lock_cnt_q < CNT_W'(LOCK_MAX)) begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
            end else begin
                lock_cnt_d = lock_cnt_q;
            end
        end else if (!req_lock[last_grant_q]) begin
            lock_cnt_d = CNT_W'(0);
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    // Lock counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= CNT_W'(0);
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    assign hold_s = 1'b0;
`endif

    rr_arb2 u_rr_arb2 (
        .valid_i    (req_valid),
        .last_i     (last_grant_q),
        .hold_i     (hold_s),
        .grant_o    (grant_s),
        .grant_id_o (grant_id_s)
    );

    // Ready is gated by reset so no requester sees an accept while in reset.
    assign req_ready  = grant_s & {2{slot_free_s & rst_n}};
    assign transfer_s = |(req_valid & req_ready);

    // With no grant grant_id_s is 0, so the ALU idles on requester 0's operands.
    assign alu_in1  = grant_id_s ? req_a1  : req_a0;
    assign alu_in2  = grant_id_s ? req_b1  : req_b0;
    assign alu_ctrl = grant_id_s ? req_op1 : req_op0;

    // Response slot next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (transfer_s) begin
                    state_d = FULL;
                end else begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (transfer_s) begin
                    state_d = FULL;
                end else if (rsp_ready) begin
                    state_d = EMPTY;
                end else begin
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register; last_grant resets to 1 so requester 0 wins first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (transfer_s) begin
                last_grant_q <= grant_id_s;
            end else begin
                last_grant_q <= last_grant_q;
            end
        end
    end

    // Response payload capture on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_q   <= 1'b0;
            rsp_data_q <= 16'h0000;
            rsp_zero_q <= 1'b0;
        end else if (transfer_s) begin
            rsp_id_q   <= grant_id_s;
            rsp_data_q <= alu_out;
            rsp_zero_q <= alu_zero;
        end else begin
            rsp_id_q   <= rsp_id_q;
            rsp_data_q <= rsp_data_q;
            rsp_zero_q <= rsp_zero_q;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter. A small
// behavioural ALU answers the arbiter's ALU port; expected responses are
// hand-computed constants. The lock scenario runs when ALU_ARB_LOCK_EN is set.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]  req_op0, req_op1;
`ifdef ALU_ARB_LOCK_EN
    logic [1:0]  req_lock;
`endif
    logic [15:0] alu_in1, alu_in2;
    logic [2:0]  alu_ctrl;
    logic [15:0] alu_out;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_ready;

    int n_checks;
    int n_errors;

    alu_arbiter #(.LOCK_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_op0   (req_op0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_op1   (req_op1),
`ifdef ALU_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-bit ALU; shifts use alu_in2[3:0] as the amount.
    always_comb begin
        logic [15:0] r;
        r = 16'h0000;
        case (alu_ctrl)
            3'b000:  r = alu_in1 + alu_in2;
            3'b001:  r = alu_in1 - alu_in2;
            3'b010:  r = ~alu_in1;
            3'b011:  r = alu_in1 << alu_in2[3:0];
            3'b100:  r = alu_in1 >> alu_in2[3:0];
            3'b101:  r = alu_in1 & alu_in2;
            3'b110:  r = alu_in1 | alu_in2;
            3'b111:  r = {15'h0000, alu_in1 < alu_in2};
            default: r = 16'h0000;
        endcase
        alu_out  = r;
        alu_zero = (r == 16'h0000);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic id,
                           input logic [15:0] data, input logic zero);
        check({tag, ".valid"}, 16'(rsp_valid), 16'(v));
        check({tag, ".id"},    16'(rsp_id),    16'(id));
        check({tag, ".data"},  rsp_data,       data);
        check({tag, ".zero"},  16'(rsp_zero),  16'(zero));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] lock_ids;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        req_a0 = 16'h0000; req_b0 = 16'h0000; req_op0 = 3'b000;
        req_a1 = 16'h0000; req_b1 = 16'h0000; req_op1 = 3'b000;
`ifdef ALU_ARB_LOCK_EN
        req_lock = 2'b00;
`endif
        #1 rst_n = 1'b0;
        #2;
        // Reset state, with both requests already valid.
        check("rst.req_ready", 16'(req_ready), 16'h0000);
        chk_rsp("rst", 1'b0, 1'b0, 16'h0000, 1'b0);
        req_valid = 2'b00;
        step();
        step();
        rst_n = 1'b1;

        // Single request: ADD 3+4.
        req_a0 = 16'h0003; req_b0 = 16'h0004; req_op0 = 3'b000;
        req_valid = 2'b01;
        #1;
        check("add.req_ready", 16'(req_ready), 16'h0001);
        check("add.alu_in1",   alu_in1,        16'h0003);
        check("add.alu_ctrl",  16'(alu_ctrl),  16'h0000);
        step();
        chk_rsp("add", 1'b1, 1'b0, 16'h0007, 1'b0);
        req_valid = 2'b00;
        step();
        check("drain.valid", 16'(rsp_valid), 16'h0000);

        // Contention after reset: req0 SUB 5-5, req1 OR F0|0F.
        reset_pulse();
        req_a0 = 16'h0005; req_b0 = 16'h0005; req_op0 = 3'b001;
        req_a1 = 16'h00F0; req_b1 = 16'h000F; req_op1 = 3'b110;
        req_valid = 2'b11;
        #1;
        check("cont.req_ready", 16'(req_ready), 16'h0001);
        step();
        chk_rsp("cont0", 1'b1, 1'b0, 16'h0000, 1'b1);
        req_valid = 2'b10;
        step();
        chk_rsp("cont1", 1'b1, 1'b1, 16'h00FF, 1'b0);

        // Continuous contention: alternating grants, one response per cycle.
        req_a0 = 16'h0001; req_b0 = 16'h0001; req_op0 = 3'b000;
        req_a1 = 16'hFFFF; req_b1 = 16'h00F0; req_op1 = 3'b101;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_rsp($sformatf("rr%0d", i), 1'b1, i[0],
                    i[0] ? 16'h00F0 : 16'h0002, 1'b0);
        end

        // Back-pressure: response holds, no request is accepted.
        rsp_ready = 1'b0;
        req_a1 = 16'h0010; req_b1 = 16'h0001; req_op1 = 3'b001;
        req_valid = 2'b10;
        #1;
        check("stall.req_ready", 16'(req_ready), 16'h0000);
        step();
        chk_rsp("stall1", 1'b1, 1'b1, 16'h00F0, 1'b0);
        step();
        chk_rsp("stall2", 1'b1, 1'b1, 16'h00F0, 1'b0);
        rsp_ready = 1'b1;
        #1;
        check("refill.req_ready", 16'(req_ready), 16'h0002);
        step();
        chk_rsp("refill", 1'b1, 1'b1, 16'h000F, 1'b0);
        req_valid = 2'b00;
        step();
        check("refill.drain", 16'(rsp_valid), 16'h0000);

        // Asynchronous reset while FULL, then first contention goes to req0.
        req_a0 = 16'h00FF; req_op0 = 3'b010;
        req_valid = 2'b01;
        step();
        chk_rsp("not", 1'b1, 1'b0, 16'hFF00, 1'b0);
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_rsp("async_rst", 1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_a0 = 16'h0003; req_b0 = 16'h0005; req_op0 = 3'b111;
        req_a1 = 16'h0100; req_b1 = 16'h0001; req_op1 = 3'b100;
        req_valid = 2'b11;
        #1;
        check("post_rst.req_ready", 16'(req_ready), 16'h0001);
        step();
        chk_rsp("slt", 1'b1, 1'b0, 16'h0001, 1'b0);
        req_valid = 2'b10;
        step();
        chk_rsp("shr", 1'b1, 1'b1, 16'h0080, 1'b0);
        req_valid = 2'b00;
        step();

`ifdef ALU_ARB_LOCK_EN
        // Locked requester 0: four grants, forced hand-over, then restart.
        reset_pulse();
        lock_ids = 6'b010000;
        req_a0 = 16'h0001; req_b0 = 16'h0001; req_op0 = 3'b000;
        req_a1 = 16'hFFFF; req_b1 = 16'h00F0; req_op1 = 3'b101;
        req_lock  = 2'b01;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("lock%0d.id", i), 16'(rsp_id), 16'(lock_ids[i]));
        end
        req_valid = 2'b00;
        req_lock  = 2'b00;
        step();
`else
        lock_ids = 6'b000000;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
